// File: rtl/jstk_poll_ctrl_if.sv
// Byte-level handshake between the poll sequencer (master) and the SPI shift engine (slave).
`timescale 1ns/1ps
interface jstk_poll_ctrl_if;
    logic       byte_req;
    logic [7:0] tx_byte;
    logic       byte_done;
    logic [7:0] rx_byte;

    modport master (output byte_req, tx_byte, input  byte_done, rx_byte);
    modport slave  (input  byte_req, tx_byte, output byte_done, rx_byte);
endinterface

// File: rtl/jstk_poll_ctrl.sv
// PmodJSTK2 poll sequencer: frames one 5-byte exchange per poll tick, owns ss and byte spacing,
// and publishes X/Y/button atomically when the last byte returns.
`timescale 1ns/1ps
module jstk_poll_ctrl #(
    parameter int unsigned POLL_CYCLES = 120000,
    parameter int unsigned SS_SETUP    = 300,
    parameter int unsigned BYTE_GAP    = 120,
    parameter int unsigned TIMEOUT     = 4095
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [23:0]            color,
    output logic                   ss,
    jstk_poll_ctrl_if.master       eng,
    output logic [9:0]             x_pos,
    output logic [9:0]             y_pos,
    output logic [1:0]             button,
    output logic                   sample_valid,
    output logic                   busy,
    output logic                   error
);

    localparam int unsigned PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned CMAX = (TIMEOUT > SS_SETUP) ?
                                   ((TIMEOUT > BYTE_GAP) ? TIMEOUT : BYTE_GAP) :
                                   ((SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP);
    localparam int unsigned CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, REQ, WAIT, GAP, DONE} state_t;

    state_t        state, state_next;
    logic [PW-1:0] poll_cnt;
    logic          tick;
    logic [CW-1:0] cnt;
    logic [2:0]    idx, idx_next;
    logic [23:0]   frame;
    logic [7:0]    x_lo, y_lo;
    logic [1:0]    x_hi, y_hi;
    logic          start, abort, got_byte, last_byte;

    // Tick is registered so it lands on the cycle the counter reads 0 after a wrap, never out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (poll_cnt == PW'(POLL_CYCLES - 1));
            poll_cnt <= (poll_cnt == PW'(POLL_CYCLES - 1)) ? '0 : poll_cnt + 1'b1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        start      = 1'b0;
        abort      = 1'b0;
        got_byte   = 1'b0;
        case (state)
            IDLE:  if (tick && enable) begin
                       state_next = SETUP;
                       idx_next   = 3'd0;
                       start      = 1'b1;
                   end
            SETUP: if (cnt == CW'(SS_SETUP - 1)) state_next = REQ;
            REQ:   state_next = WAIT;
            WAIT:  if (eng.byte_done) begin
                       got_byte   = 1'b1;
                       state_next = (idx == 3'd4) ? DONE : GAP;
                   end else if (cnt == CW'(TIMEOUT - 1)) begin
                       abort      = 1'b1;
                       state_next = IDLE;
                   end
            GAP:   if (cnt == CW'(BYTE_GAP - 1)) begin
                       state_next = REQ;
                       idx_next   = idx + 3'd1;
                   end
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign last_byte = got_byte && (idx == 3'd4);

    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= 3'd0;
            ss           <= 1'b1;
            eng.byte_req <= 1'b0;
            eng.tx_byte  <= 8'h00;
            x_pos        <= 10'd0;
            y_pos        <= 10'd0;
            button       <= 2'd0;
            sample_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= (state_next != state) ? '0 : cnt + 1'b1;
            idx          <= idx_next;
            ss           <= (state_next == IDLE) || (state_next == DONE);
            eng.byte_req <= (state_next == REQ);
            error        <= abort;
            sample_valid <= last_byte;
            if (state_next == REQ) begin
                case (idx_next)
                    3'd0:    eng.tx_byte <= 8'h84;
                    3'd1:    eng.tx_byte <= frame[23:16];
                    3'd2:    eng.tx_byte <= frame[15:8];
                    3'd3:    eng.tx_byte <= frame[7:0];
                    default: eng.tx_byte <= 8'h00;
                endcase
            end
            // The button byte is taken straight off the bus so all fields publish on the same edge.
            if (last_byte) begin
                x_pos  <= {x_hi, x_lo};
                y_pos  <= {y_hi, y_lo};
                button <= eng.rx_byte[1:0];
            end
        end
    end

    // NOTE: frame and shadow bytes are pure data qualified by the FSM, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start) frame <= color;
        if (got_byte) begin
            case (idx)
                3'd0:    x_lo <= eng.rx_byte;
                3'd1:    x_hi <= eng.rx_byte[1:0];
                3'd2:    y_lo <= eng.rx_byte;
                3'd3:    y_hi <= eng.rx_byte[1:0];
                default: ;
            endcase
        end
    end

    assign busy = ~ss;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Directed bench for jstk_poll_ctrl with a behavioural SPI byte engine answering LAT cycles after byte_req.
`timescale 1ns/1ps
module tb_jstk_poll_ctrl;

    localparam int P   = 400;
    localparam int S   = 10;
    localparam int G   = 5;
    localparam int TO  = 60;
    localparam int LAT = 20;
    localparam int NONE = 7;

    localparam int W_FALL = 0, W_SV = 1, W_ERR = 2, W_REQ = 3, W_DONE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] color = 24'h0;
    logic        ss, sample_valid, busy, error;
    logic [9:0]  x_pos, y_pos;
    logic [1:0]  button;

    jstk_poll_ctrl_if eng ();

    jstk_poll_ctrl #(.POLL_CYCLES(P), .SS_SETUP(S), .BYTE_GAP(G), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .color(color), .ss(ss), .eng(eng),
        .x_pos(x_pos), .y_pos(y_pos), .button(button), .sample_valid(sample_valid),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: ss edges, sample_valid and error pulses, seen mid-cycle.
    int   fall_cyc = -1, rise_cyc = -1, sv_cyc = -1, err_cyc = -1;
    int   fall_cnt = 0, sv_cnt = 0, err_cnt = 0;
    logic ss_prev = 1'b1;
    always @(negedge clk) begin
        if (ss_prev === 1'b1 && ss === 1'b0) begin fall_cyc = cyc; fall_cnt++; end
        if (ss_prev === 1'b0 && ss === 1'b1) rise_cyc = cyc;
        ss_prev = ss;
        if (sample_valid === 1'b1) begin sv_cyc = cyc; sv_cnt++; end
        if (error === 1'b1) begin err_cyc = cyc; err_cnt++; end
    end

    // Engine model: records each request, answers LAT cycles later unless told to drop that byte.
    int         req_cyc [8];
    int         done_cyc[8];
    logic [7:0] tx_seen [8];
    logic [7:0] rx_tab  [8];
    int         req_n = 0, done_cnt = 0, req_wide = 0, drop_idx = NONE;
    initial begin
        int k;
        eng.byte_done = 1'b0;
        eng.rx_byte   = 8'h00;
        forever begin
            @(negedge clk);
            if (eng.byte_req === 1'b1) begin
                k = req_n & 7;
                req_cyc[k] = cyc;
                tx_seen[k] = eng.tx_byte;
                req_n++;
                @(negedge clk);
                if (eng.byte_req !== 1'b0) req_wide++;
                if (k != drop_idx) begin
                    repeat (LAT - 1) @(negedge clk);
                    eng.byte_done = 1'b1;
                    eng.rx_byte   = rx_tab[k];
                    done_cyc[k]   = cyc;
                    done_cnt++;
                    @(negedge clk);
                    eng.byte_done = 1'b0;
                    eng.rx_byte   = 8'h00;
                end
            end
        end
    end

    function automatic int counter_of(input int which);
        case (which)
            W_FALL:  return fall_cnt;
            W_SV:    return sv_cnt;
            W_ERR:   return err_cnt;
            W_REQ:   return req_n;
            default: return done_cnt;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, input string tag);
        int n = 0;
        while (counter_of(which) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(counter_of(which) >= target), 32'd1);
    endtask

    int rel, fa, fb, fc;
    logic [7:0] exp_tx [5];

    initial begin
        for (int i = 0; i < 8; i++) rx_tab[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ss", 32'(ss), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_byte_req", 32'(eng.byte_req), 32'd0);
        check("rst_tx_byte", 32'(eng.tx_byte), 32'h00);
        check("rst_xyb", {x_pos, y_pos, button, sample_valid, error}, 32'd0);
        rel = cyc;
        rst_n = 1'b1;

        // Frame A: normal frame, color changed after it starts
        enable = 1'b1;
        color  = 24'h123456;
        rx_tab[0] = 8'hF4; rx_tab[1] = 8'h01; rx_tab[2] = 8'h20; rx_tab[3] = 8'h03; rx_tab[4] = 8'h02;
        wait_for(W_FALL, 1, P + 20, "a_ss_fall_seen");
        fa = fall_cyc;
        check("a_ss_fall_cycle", 32'(fa), 32'(rel + P + 1));
        check("a_busy", 32'(busy), 32'd1);
        color = 24'hAABBCC;
        wait_for(W_SV, 1, 400, "a_sample_seen");
        @(negedge clk);
        exp_tx[0] = 8'h84; exp_tx[1] = 8'h12; exp_tx[2] = 8'h34; exp_tx[3] = 8'h56; exp_tx[4] = 8'h00;
        check("a_req_count", 32'(req_n), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("a_tx%0d", i), 32'(tx_seen[i]), 32'(exp_tx[i]));
        check("a_setup_spacing", 32'(req_cyc[0]), 32'(fa + S));
        for (int i = 1; i < 5; i++)
            check($sformatf("a_gap%0d", i), 32'(req_cyc[i]), 32'(done_cyc[i-1] + G + 1));
        check("a_x_pos", 32'(x_pos), 32'h1F4);
        check("a_y_pos", 32'(y_pos), 32'h320);
        check("a_button", 32'(button), 32'd2);
        check("a_ss_rise", 32'(rise_cyc), 32'(done_cyc[4] + 1));
        check("a_sv_with_rise", 32'(sv_cyc), 32'(rise_cyc));
        check("a_sv_single", 32'(sv_cnt), 32'd1);
        check("a_busy_end", 32'(busy), 32'd0);

        // Frame B: byte 2 never answered -> timeout abort
        req_n = 0;
        drop_idx = 2;
        wait_for(W_ERR, 1, P + 200, "b_error_seen");
        fb = fall_cyc;
        @(negedge clk);
        check("b_ss_fall_cycle", 32'(fb), 32'(fa + P));
        check("b_err_cycle", 32'(err_cyc), 32'(req_cyc[2] + TO + 1));
        check("b_err_abs", 32'(err_cyc), 32'(fb + S + 2 * (LAT + 1 + G) + TO + 1));
        check("b_ss_rise", 32'(rise_cyc), 32'(err_cyc));
        check("b_req_count", 32'(req_n), 32'd3);
        check("b_err_single", 32'(err_cnt), 32'd1);
        check("b_x_kept", 32'(x_pos), 32'h1F4);
        check("b_y_kept", 32'(y_pos), 32'h320);
        check("b_button_kept", 32'(button), 32'd2);
        check("b_no_sample", 32'(sv_cnt), 32'd1);

        // Frame C: normal after abort; enable dropped during byte 3
        req_n = 0;
        drop_idx = NONE;
        rx_tab[0] = 8'h55; rx_tab[1] = 8'h02; rx_tab[2] = 8'hAA; rx_tab[3] = 8'h01; rx_tab[4] = 8'h01;
        wait_for(W_FALL, 3, P + 20, "c_ss_fall_seen");
        fc = fall_cyc;
        check("c_ss_fall_cycle", 32'(fc), 32'(fa + 2 * P));
        wait_for(W_REQ, 4, 300, "c_byte3_seen");
        enable = 1'b0;
        wait_for(W_SV, 2, 300, "c_sample_seen");
        @(negedge clk);
        check("c_x_pos", 32'(x_pos), 32'h255);
        check("c_y_pos", 32'(y_pos), 32'h1AA);
        check("c_button", 32'(button), 32'd1);
        check("c_tx4", 32'(tx_seen[4]), 32'h00);
        repeat (2 * P + 10) @(negedge clk);
        check("c_no_frames_disabled", 32'(fall_cnt), 32'd3);

        // Frame D: re-enable, then async reset during GAP
        req_n = 0;
        done_cnt = 0;
        enable = 1'b1;
        wait_for(W_FALL, 4, P + 20, "d_ss_fall_seen");
        check("d_tick_aligned", 32'((fall_cyc - fa) % P), 32'd0);
        wait_for(W_DONE, 2, 300, "d_byte1_done");
        @(negedge clk);
        check("d_in_frame", 32'(ss), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("d_async_ss", 32'(ss), 32'd1);
        check("d_async_busy", 32'(busy), 32'd0);
        check("d_async_byte_req", 32'(eng.byte_req), 32'd0);
        check("d_async_tx_byte", 32'(eng.tx_byte), 32'h00);
        check("d_async_x_pos", 32'(x_pos), 32'd0);
        check("d_async_y_pos", 32'(y_pos), 32'd0);
        check("d_async_button", 32'(button), 32'd0);
        check("d_async_pulses", {30'd0, sample_valid, error}, 32'd0);
        @(negedge clk);
        rel = cyc;
        rst_n = 1'b1;
        wait_for(W_FALL, 5, P + 20, "e_ss_fall_seen");
        check("e_ss_fall_cycle", 32'(fall_cyc), 32'(rel + P + 1));
        check("byte_req_width", 32'(req_wide), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jstk_poll_ctrl.md
# jstk_poll_ctrl

Periodic poll sequencer for the PmodJSTK2 joystick. On a fixed poll interval it frames one 5-byte SPI exchange through the byte-level SPI engine: it sends the set-RGB command carrying the current 24-bit color, and collects X position, Y position and button state. Results are published atomically to the LED/display logic downstream. It owns slave-select and all inter-byte spacing, so the SPI engine only shifts single bytes on request.

## Interface

Parameters:
- POLL_CYCLES, 120000 — clock cycles between poll ticks (10 ms at 12 MHz)
- SS_SETUP, 300 — cycles from ss falling to first byte_req (25 us)
- BYTE_GAP, 120 — cycles from byte_done to next byte_req (10 us)
- TIMEOUT, 4095 — max cycles waiting for byte_done before abort

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  polling allowed
- color  in  24  {R[23:16], G[15:8], B[7:0]} for the JSTK2 RGB LED
- ss  out  1  joystick slave-select, active low
- byte_req  out  1  one-cycle request to SPI engine to shift tx_byte
- tx_byte  out  8  byte to transmit
- byte_done  in  1  one-cycle pulse, byte shifted; rx_byte valid this cycle
- rx_byte  in  8  byte received
- x_pos  out  10  joystick X
- y_pos  out  10  joystick Y
- button  out  2  bit0 stick press, bit1 trigger
- sample_valid  out  1  one-cycle pulse when x_pos/y_pos/button update
- busy  out  1  frame in progress (ss low)
- error  out  1  one-cycle pulse on timeout abort

## Operation

- Reset values: ss=1, byte_req=0, tx_byte=0x00, x_pos=0, y_pos=0, button=0, sample_valid=0, busy=0, error=0; poll counter=0, state IDLE.
- Poll counter is free-running 0..POLL_CYCLES-1. A tick is asserted when the counter wraps to 0.
- States: IDLE, SETUP, REQ, WAIT, GAP, DONE.
- IDLE: on tick with enable=1, capture color into a frame register, set idx=0, drive ss=0, go to SETUP. A tick arriving outside IDLE is dropped, not queued.
- SETUP: count SS_SETUP cycles, then go to REQ.
- REQ: pulse byte_req for one cycle and present tx_byte by idx: 0→0x84, 1→R, 2→G, 3→B, 4→0x00. Go to WAIT. tx_byte holds until byte_done.
- WAIT: on byte_done, store rx_byte into shadow[idx].
  - If idx<4, go to GAP.
  - If idx=4, go to DONE.
  - If no byte_done within TIMEOUT cycles, abort: ss=1, pulse error, go to IDLE; published outputs are unchanged.
- GAP: count BYTE_GAP cycles, idx++, then go to REQ.
- DONE (one cycle): ss=1, then publish:
  - x_pos={shadow1[1:0],shadow0}
  - y_pos={shadow3[1:0],shadow2}
  - button=shadow4[1:0]
  - pulse sample_valid, go to IDLE.
- byte_done outside WAIT is ignored.
- Dropping enable mid-frame does not abort the frame; it only blocks new frames.
- Changes to color mid-frame do not affect the frame in progress.
- busy = ~ss.

## Timing

- Tick at cycle T (IDLE, enable=1): ss=0 and busy=1 registered at T+1.
- First byte_req high at T+1+SS_SETUP, for exactly one cycle.
- byte_done at cycle n (idx<4): next byte_req at n+1+BYTE_GAP.
- byte_done at cycle n (idx=4): at n+1, ss=1, busy=0, outputs updated, sample_valid=1. IDLE at n+2.
- Timeout: byte_req at cycle r with no byte_done through r+TIMEOUT gives ss=1 and error=1 at r+TIMEOUT+1.
- Back-to-back frames are spaced by POLL_CYCLES. A frame never overlaps its successor; an overlapping tick is lost.
- Asynchronous reset mid-frame: ss=1 and all outputs go to their reset values immediately, independent of clk.

## Test plan

- Reset, then enable=1, color=0x12_34_56, with a model engine echoing byte_done 20 cycles after each byte_req → tx sequence 0x84,0x12,0x34,0x56,0x00; ss low from tick+1 through the final byte_done+1.
- Model rx bytes 0xF4,0x01,0x20,0x03,0x02 → x_pos=0x1F4, y_pos=0x320, button=2b10, one sample_valid pulse coincident with ss rising.
- Check spacing: first byte_req exactly SS_SETUP cycles after ss falls; each later byte_req exactly BYTE_GAP+1 cycles after the preceding byte_done.
- Engine never returns byte_done on byte 2 → error pulse at byte_req+TIMEOUT+1, ss=1, x/y/button keep the previous frame's values, next tick starts a normal frame.
- enable=0 during byte 3 → frame completes with sample_valid; no ss activity on following ticks until enable=1. Change color mid-frame → transmitted R/G/B bytes match the value captured at the frame-start tick.
- Assert rst_n=0 during GAP → ss=1 and all outputs at reset values without waiting for a clock edge; release gives the first frame on the next counter wrap.
